// File: rtl/deglitch_gea1.sv
`default_nettype none
// ============================================================================
// Module  : deglitch_gea1
// Brief   : Synchronises an async input and accepts a new level only after it
//           is stable for FILT_CYCLES clocks; emits one-cycle rise/fall strobes.
// Revision: 1.0
// ============================================================================
module deglitch_gea1 #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic en,
    output logic y,
    output logic rise,
    output logic fall,
    output logic filt_busy
);

    localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   y_q;
    logic                   y_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   w_s;

    // Only sync_q[0] ever samples the asynchronous input.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], a};
    assign w_s    = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        y_d    = y_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (w_s == y_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_LAST) begin
            y_d    = w_s;
            cnt_d  = '0;
            rise_d = w_s;
            fall_d = ~w_s;
        end else begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cnt_q  <= '0;
            y_q    <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign y         = y_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign filt_busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_deglitch_gea1.sv
`default_nettype none
// ============================================================================
// Module  : tb_deglitch_gea1
// Brief   : Scoreboard bench for deglitch_gea1 (default build and FILT_CYCLES=1).
// Revision: 1.0
// ============================================================================
module tb_deglitch_gea1;

    typedef struct {
        int unit;
        bit is_rise;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic a_a, a_b, en;
    logic y_a, rise_a, fall_a, busy_a;
    logic y_b, rise_b, fall_b, busy_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    deglitch_gea1 #(.SYNC_STAGES(2), .FILT_CYCLES(4), .RESET_VAL(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .a(a_a), .en(en),
        .y(y_a), .rise(rise_a), .fall(fall_a), .filt_busy(busy_a)
    );

    deglitch_gea1 #(.SYNC_STAGES(2), .FILT_CYCLES(1), .RESET_VAL(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .a(a_b), .en(en),
        .y(y_b), .rise(rise_b), .fall(fall_b), .filt_busy(busy_b)
    );

    task automatic chk(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int unit, input bit is_rise, input int at_cyc);
        ev_t e;
        e.unit = unit;
        e.is_rise = is_rise;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    task automatic mon_unit(input int u, input logic yv, input logic rv, input logic fv);
        ev_t e;
        if (rv && fv) begin
            total++;
            bad++;
            $display("FAIL strobe_excl unit%0d: rise and fall both high (cyc %0d)", u, cyc);
        end else if (rv || fv) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe unit%0d: got rise=%0b fall=%0b at cyc %0d, expected none",
                         u, rv, fv, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.unit != u || e.is_rise != rv || e.cyc != cyc || yv !== rv) begin
                    bad++;
                    $display("FAIL strobe unit%0d: got rise=%0b y=%0b cyc=%0d, expected unit%0d rise=%0b cyc=%0d",
                             u, rv, yv, cyc, e.unit, e.is_rise, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_unit(0, y_a, rise_a, fall_a);
            mon_unit(1, y_b, rise_b, fall_b);
        end
    end

    initial begin
        bit saw_busy;
        int c;
        rst_n = 1'b0;
        a_a   = 1'b0;
        a_b   = 1'b0;
        en    = 1'b1;
        step(3);
        chk("reset_y", y_a, 1'b0);
        chk("reset_rise", rise_a, 1'b0);
        chk("reset_fall", fall_a, 1'b0);
        chk("reset_busy", busy_a, 1'b0);

        // Test 1: release reset with a=1 held; y rises after edge 6.
        a_a   = 1'b1;
        rst_n = 1'b1;
        c = cyc;
        expect_ev(0, 1'b1, c + 6);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk($sformatf("t1_y_edge%0d", k), y_a, (k >= 6) ? 1'b1 : 1'b0);
        end
        step(3);
        a_a = 1'b0;
        expect_ev(0, 1'b0, cyc + 6);
        step(8);

        // Test 2: 3-clock pulse is rejected.
        a_a = 1'b1;
        saw_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) a_a = 1'b0;
            step(1);
            if (busy_a) saw_busy = 1'b1;
        end
        chk("t2_busy_seen", saw_busy, 1'b1);
        chk("t2_busy_clear", busy_a, 1'b0);
        chk("t2_y", y_a, 1'b0);

        // Test 3: exactly 4-clock pulse passes, then falls 4 edges after rise.
        c = cyc;
        a_a = 1'b1;
        expect_ev(0, 1'b1, c + 6);
        expect_ev(0, 1'b0, c + 10);
        step(4);
        a_a = 1'b0;
        step(10);
        chk("t3_y_final", y_a, 1'b0);

        // Test 4: bounce every 2 clocks for 20 clocks, then settle high.
        for (int i = 0; i < 10; i++) begin
            a_a = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(2);
            chk($sformatf("t4_bounce_y%0d", i), y_a, 1'b0);
        end
        a_a = 1'b1;
        expect_ev(0, 1'b1, cyc + 6);
        step(8);
        chk("t4_y_settled", y_a, 1'b1);
        a_a = 1'b0;
        expect_ev(0, 1'b0, cyc + 6);
        step(8);

        // Test 5: en low freezes y; after raising en, 4 enabled edges.
        en  = 1'b0;
        a_a = 1'b1;
        step(10);
        chk("t5_y_frozen", y_a, 1'b0);
        chk("t5_busy_frozen", busy_a, 1'b0);
        en = 1'b1;
        expect_ev(0, 1'b1, cyc + 4);
        step(6);
        chk("t5_y_after_en", y_a, 1'b1);

        // Test 6: async reset mid-count discards the pending change.
        a_a = 1'b0;
        expect_ev(0, 1'b0, cyc + 6);
        step(8);
        a_a = 1'b1;
        step(4);
        chk("t6_busy_midcount", busy_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_y", y_a, 1'b0);
        chk("t6_async_busy", busy_a, 1'b0);
        chk("t6_async_rise", rise_a, 1'b0);
        chk("t6_async_fall", fall_a, 1'b0);
        step(3);
        chk("t6_hold_y", y_a, 1'b0);
        a_a   = 1'b0;
        rst_n = 1'b1;
        step(4);

        // FILT_CYCLES=1 build: 3-edge latency, single-cycle glitch passes.
        c = cyc;
        a_b = 1'b1;
        expect_ev(1, 1'b1, c + 3);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk($sformatf("b_y_edge%0d", k), y_b, (k >= 3) ? 1'b1 : 1'b0);
        end
        step(2);
        c = cyc;
        a_b = 1'b0;
        expect_ev(1, 1'b0, c + 3);
        expect_ev(1, 1'b1, c + 4);
        step(1);
        a_b = 1'b1;
        step(8);
        chk("b_y_final", y_b, 1'b1);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes: got %0d unconsumed, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
